// File: rtl/score_display_pkg.sv
// Shared types, glyph constants and width helper for the score display
// and its decoder.
package score_display_pkg;

   typedef logic [3:0] bcd_t;

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   // Bits needed to hold 0..value-1; never below 1 so single-state counters stay legal.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder with a blank override.
module seg7_decode (
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);
   import score_display_pkg::*;

   always_comb begin
      seg_o = GLYPH_BLANK;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = GLYPH_0;
            4'd1:    seg_o = GLYPH_1;
            4'd2:    seg_o = GLYPH_2;
            4'd3:    seg_o = GLYPH_3;
            4'd4:    seg_o = GLYPH_4;
            4'd5:    seg_o = GLYPH_5;
            4'd6:    seg_o = GLYPH_6;
            4'd7:    seg_o = GLYPH_7;
            4'd8:    seg_o = GLYPH_8;
            4'd9:    seg_o = GLYPH_9;
            default: seg_o = GLYPH_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/score_display.sv
// N-digit BCD score counter with overflow flag, driving a multiplexed
// 7-segment display with leading-zero blanking, blink and polarity control.
module score_display #(
   parameter int DIGITS            = 4,
   parameter int TICKS_PER_SCAN    = 50,
   parameter int BLINK_HALF_FRAMES = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ena_i,
   input  logic                  invert_i,
   input  logic                  inc_i,
   input  logic                  dec_i,
   input  logic                  clr_i,
   input  logic                  blink_i,
   input  logic                  blank_zeros_i,
   output logic [6:0]            segments_o,
   output logic [DIGITS-1:0]     digits_o,
   output logic [4*DIGITS-1:0]   value_o,
   output logic                  overflow_o
);
   import score_display_pkg::*;

   localparam int IDX_W = clog2(DIGITS);
   localparam int PRE_W = clog2(TICKS_PER_SCAN);
   localparam int FRM_W = clog2(BLINK_HALF_FRAMES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SCAN - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_HALF_FRAMES - 1);

   logic [4*DIGITS-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
   logic                ovf_q, ovf_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [FRM_W-1:0]    frm_q, frm_d;
   logic                phase_q, phase_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   dig_q, dig_d;
   logic [DIGITS-1:0]   upper_zero;
   logic                all_nine, is_zero;
   bcd_t                cur_digit;
   logic                cur_upper_zero, blank;

   // Per-digit carry, borrow and "this digit and all above are zero" chains.
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_t d;
      logic cin, bin, cout, bout, uz;
      assign d = cnt_q[4*k +: 4];
      if (k == 0) begin : g_lsd
         assign cin = 1'b1;
         assign bin = 1'b1;
      end else begin : g_chain
         assign cin = g_digit[k-1].cout;
         assign bin = g_digit[k-1].bout;
      end
      if (k == DIGITS - 1) begin : g_msd
         assign uz = (d == 4'd0);
      end else begin : g_upper
         assign uz = (d == 4'd0) & g_digit[k+1].uz;
      end
      assign cout          = cin & (d == 4'd9);
      assign bout          = bin & (d == 4'd0);
      assign upper_zero[k] = uz;
      assign cnt_inc[4*k +: 4] = !cin ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
      assign cnt_dec[4*k +: 4] = !bin ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
   end

   assign all_nine = g_digit[DIGITS-1].cout;
   assign is_zero  = g_digit[DIGITS-1].bout;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc_i && !dec_i) begin
         cnt_d = cnt_inc;
         if (all_nine) ovf_d = 1'b1;
      end else if (dec_i && !inc_i && !is_zero) begin
         cnt_d = cnt_dec;
      end
   end

   // Prescaler -> digit index -> frame counter -> blink phase.
   always_comb begin
      pre_d   = pre_q + PRE_W'(1);
      idx_d   = idx_q;
      frm_d   = frm_q;
      phase_d = phase_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (frm_q == FRM_LAST) begin
               frm_d   = '0;
               phase_d = ~phase_q;
            end else begin
               frm_d = frm_q + FRM_W'(1);
            end
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      cur_digit      = '0;
      cur_upper_zero = 1'b0;
      dig_d          = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_digit      = cnt_q[4*k +: 4];
            cur_upper_zero = upper_zero[k];
            dig_d[k]       = 1'b1;
         end
      end
      blank = !ena_i || (blink_i && phase_q) ||
              (blank_zeros_i && (idx_q != '0) && cur_upper_zero);
   end

   seg7_decode u_decode (
      .bcd_i   (cur_digit),
      .blank_i (blank),
      .seg_o   (seg_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         pre_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
         seg_q   <= '0;
         dig_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
      end
   end

   assign segments_o = seg_q ^ {7{invert_i}};
   assign digits_o   = dig_q ^ {DIGITS{invert_i}};
   assign value_o    = cnt_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_score_display.sv
// Randomized and directed bench for score_display against an integer-count
// reference model of the counter and scan timing.
module tb_score_display;

   localparam int D = 3;
   localparam int T = 2;
   localparam int B = 2;

   logic         clk = 1'b0;
   logic         rst_n, ena, invert, inc, dec, clr, blink, blank_zeros;
   logic [6:0]   segments;
   logic [D-1:0] digits;
   logic [4*D-1:0] value;
   logic         overflow;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state: plain integer count and edges since reset release.
   int mcnt  = 0;
   bit movf  = 1'b0;
   int n_edge = 0;
   logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   score_display #(.DIGITS(D), .TICKS_PER_SCAN(T), .BLINK_HALF_FRAMES(B)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .ena_i         (ena),
      .invert_i      (invert),
      .inc_i         (inc),
      .dec_i         (dec),
      .clr_i         (clr),
      .blink_i       (blink),
      .blank_zeros_i (blank_zeros),
      .segments_o    (segments),
      .digits_o      (digits),
      .value_o       (value),
      .overflow_o    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   function automatic int pow10(input int e);
      int p = 1;
      for (int i = 0; i < e; i++) p *= 10;
      return p;
   endfunction

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      for (int i = 0; i < D; i++) r |= 32'((v / pow10(i)) % 10) << (4 * i);
      return r;
   endfunction

   // One clock: model what the display registers load on this edge, update the
   // count, then compare all outputs just after the edge.
   task automatic step();
      int idx, phase, dv;
      bit zb, blanked;
      logic [6:0] exp_seg;
      logic [D-1:0] exp_dig;
      @(posedge clk);
      idx     = (n_edge / T) % D;
      phase   = (n_edge / (T * D * B)) % 2;
      dv      = (mcnt / pow10(idx)) % 10;
      zb      = blank_zeros && idx > 0 && mcnt < pow10(idx);
      blanked = !ena || (blink && phase == 1) || zb;
      exp_seg = blanked ? 7'h00 : glyph[dv];
      exp_dig = D'(1) << idx;
      if (clr) begin
         mcnt = 0;
         movf = 1'b0;
      end else if (inc && !dec) begin
         if (mcnt == pow10(D) - 1) begin
            mcnt = 0;
            movf = 1'b1;
         end else begin
            mcnt++;
         end
      end else if (dec && !inc && mcnt > 0) begin
         mcnt--;
      end
      n_edge++;
      #1;
      check("segments", 32'(segments), 32'(exp_seg ^ {7{invert}}));
      check("digits",   32'(digits),   32'(exp_dig ^ {D{invert}}));
      check("value",    32'(value),    to_bcd(mcnt));
      check("overflow", 32'(overflow), 32'(movf));
      @(negedge clk);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic pulse_inc(input int count);
      for (int i = 0; i < count; i++) begin
         inc = 1'b1; step();
         inc = 1'b0; step();
      end
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; invert = 1'b0; inc = 1'b0; dec = 1'b0;
      clr = 1'b0; blink = 1'b0; blank_zeros = 1'b0;
      #1;
      check("rst_segments", 32'(segments), 32'h00);
      check("rst_digits",   32'(digits),   32'h0);
      check("rst_value",    32'(value),    32'h000);
      check("rst_overflow", 32'(overflow), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle scan: digit select cycles 001,010,100 each held T cycles.
      run(20);

      // Carry chain and wrap with overflow, then clear.
      pulse_inc(1000);
      check("wrap_value", 32'(value), 32'h000);
      check("wrap_overflow", 32'(overflow), 32'h1);
      clr = 1'b1; step(); clr = 1'b0;
      check("clr_overflow", 32'(overflow), 32'h0);

      // Priority cases.
      dec = 1'b1; step(); dec = 1'b0;
      check("dec_at_zero", 32'(value), 32'h000);
      pulse_inc(4);
      inc = 1'b1; dec = 1'b1; step(); inc = 1'b0; dec = 1'b0;
      check("inc_and_dec", 32'(value), 32'h004);
      clr = 1'b1; inc = 1'b1; step(); clr = 1'b0; inc = 1'b0;
      check("clr_over_inc", 32'(value), 32'h000);

      // Leading-zero blanking at value 7.
      pulse_inc(7);
      blank_zeros = 1'b1; run(12);
      blank_zeros = 1'b0; run(12);

      // Blink, then display disabled.
      blink = 1'b1; run(48);
      blink = 1'b0; ena = 1'b0; run(18);
      ena = 1'b1;

      // Inversion with value 8.
      clr = 1'b1; step(); clr = 1'b0;
      pulse_inc(8);
      invert = 1'b1; run(12);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r   = $urandom_range(0, 99);
         inc = (r < 35);
         dec = (r >= 25 && r < 60);
         clr = ($urandom_range(0, 63) == 0);
         if (i % 150 == 0) begin
            ena         = ($urandom_range(0, 3) != 0);
            blink       = $urandom_range(0, 1);
            blank_zeros = $urandom_range(0, 1);
            invert      = $urandom_range(0, 1);
         end
         step();
      end
      inc = 1'b0; dec = 1'b0; clr = 1'b0;
      ena = 1'b1; blink = 1'b0;

      // Asynchronous reset mid-cycle with a nonzero count.
      clr = 1'b1; step(); clr = 1'b0;
      pulse_inc(5);
      invert = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_segments", 32'(segments), 32'h7F);
      check("arst_digits",   32'(digits),   32'h7);
      check("arst_value",    32'(value),    32'h000);
      check("arst_overflow", 32'(overflow), 32'h0);
      mcnt = 0; movf = 1'b0; n_edge = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(30);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
